// File: rtl/ddr_wr_arbiter_nch_if.sv
// Command and data handshake bundle between the N-channel write arbiter
// (master side) and the DDR3 AXI write master (slave side).
interface ddr_wr_arbiter_nch_if #(
    parameter int CH_NUM = 4,
    parameter int ADDR_W = 29,
    parameter int LEN_W  = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [2:0]        cmd_ch;
    logic [CH_NUM-1:0] grant;
    logic              data_beat;
    logic              data_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_ch, grant,
        input  cmd_ready, data_beat, data_last
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_ch, grant,
        output cmd_ready, data_beat, data_last
    );
endinterface

// File: rtl/ddr_wr_arbiter_nch.sv
// N-channel write arbiter and address generator. Picks one eligible
// camera FIFO per burst in round-robin order, issues an AXI-style write
// command, steers the FIFO read select during the data phase and keeps
// a per-channel frame offset and ping-pong bank.
module ddr_wr_arbiter_nch #(
    parameter int CH_NUM     = 4,
    parameter int ADDR_W     = 29,
    parameter int LEN_W      = 8,
    parameter int CNT_W      = 10,
    parameter int BEAT_BYTES = 32,
    parameter int PINGPANG   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM-1:0]        ch_load,
    input  logic [CH_NUM*CNT_W-1:0]  ch_fifo_cnt,
    input  logic [CH_NUM*ADDR_W-1:0] ch_beg_addr,
    input  logic [CH_NUM*ADDR_W-1:0] ch_end_addr,
    input  logic [LEN_W-1:0]         burst_len,
    ddr_wr_arbiter_nch_if.master     wr,
    output logic [CH_NUM-1:0]        ch_bank,
    output logic [CH_NUM-1:0]        ch_frame_done,
    output logic                     busy,
    output logic                     len_err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_nx;
    logic [2:0]        ptr_r, sel_r;
    logic [LEN_W-1:0]  len_r, beat_cnt_r;
    logic [ADDR_W-1:0] off_r [CH_NUM];
    logic [CH_NUM-1:0] bank_r, pend_r;

    logic [ADDR_W-1:0] beg_s  [CH_NUM];
    logic [ADDR_W-1:0] span_s [CH_NUM];
    logic [CH_NUM-1:0] elig_s, sel_onehot_s;
    logic              win_found_s;
    logic [2:0]        win_s;
    int                dist_s, best_s;
    logic [ADDR_W-1:0] win_addr_s, sel_off_s, sel_span_s, inc_s, off_next_s;
    logic [ADDR_W:0]   off_sum_s;
    logic [LEN_W:0]    beat_inc_s;
    logic              hit_s, active_s, tog_s;

    assign ch_bank  = bank_r;
    assign active_s = (state_r != ST_IDLE);
    assign tog_s    = (PINGPANG != 0);

    // Unpack per-channel buses and decide which channels may win a burst.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            beg_s[i]  = ch_beg_addr[i*ADDR_W +: ADDR_W];
            span_s[i] = ch_end_addr[i*ADDR_W +: ADDR_W] - ch_beg_addr[i*ADDR_W +: ADDR_W];
            elig_s[i] = (burst_len != {LEN_W{1'b0}}) &&
                        (32'(ch_fifo_cnt[i*CNT_W +: CNT_W]) >= 32'(burst_len)) &&
                        !pend_r[i] && !ch_load[i];
        end
    end

    // Round-robin pick: eligible channel closest after the last winner.
    always_comb begin
        best_s     = CH_NUM;
        dist_s     = 0;
        win_s      = 3'd0;
        win_addr_s = {ADDR_W{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            dist_s = (i + 2 * CH_NUM - int'(ptr_r) - 1) % CH_NUM;
            if (elig_s[i] && (dist_s < best_s)) begin
                best_s     = dist_s;
                win_s      = 3'(i);
                win_addr_s = beg_s[i] + off_r[i] + (bank_r[i] ? span_s[i] : {ADDR_W{1'b0}});
            end else begin
                best_s = best_s;
            end
        end
        win_found_s = (best_s < CH_NUM);
    end

    // Selected-channel view: offset advance with wrap, read select and beat count.
    always_comb begin
        sel_off_s    = {ADDR_W{1'b0}};
        sel_span_s   = {ADDR_W{1'b0}};
        sel_onehot_s = {CH_NUM{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            if (3'(i) == sel_r) begin
                sel_off_s       = off_r[i];
                sel_span_s      = span_s[i];
                sel_onehot_s[i] = 1'b1;
            end else begin
                sel_onehot_s[i] = 1'b0;
            end
        end
        inc_s      = ADDR_W'(len_r) * ADDR_W'(BEAT_BYTES);
        off_sum_s  = {1'b0, sel_off_s} + {1'b0, inc_s};
        off_next_s = (off_sum_s >= {1'b0, sel_span_s}) ? {ADDR_W{1'b0}} : off_sum_s[ADDR_W-1:0];
        beat_inc_s = {1'b0, beat_cnt_r} + {{LEN_W{1'b0}}, 1'b1};
        hit_s      = (beat_inc_s == {1'b0, len_r});
    end

    // Next-state logic for the burst FSM.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) state_nx = ST_CMD;
                else             state_nx = ST_IDLE;
            end
            ST_CMD: begin
                if (wr.cmd_ready) state_nx = ST_DATA;
                else              state_nx = ST_CMD;
            end
            ST_DATA: begin
                if (wr.data_beat && (hit_s || wr.data_last)) state_nx = ST_DONE;
                else                                         state_nx = ST_DATA;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM state, registered command/grant outputs, beat counter and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= 3'd0;
            sel_r        <= 3'd0;
            len_r        <= {LEN_W{1'b0}};
            beat_cnt_r   <= {LEN_W{1'b0}};
            len_err      <= 1'b0;
            busy         <= 1'b0;
            wr.cmd_valid <= 1'b0;
            wr.cmd_addr  <= {ADDR_W{1'b0}};
            wr.cmd_len   <= {LEN_W{1'b0}};
            wr.cmd_ch    <= 3'd0;
            wr.grant     <= {CH_NUM{1'b0}};
        end else begin
            state_r      <= state_nx;
            busy         <= (state_nx != ST_IDLE);
            wr.cmd_valid <= (state_nx == ST_CMD);
            wr.grant     <= (state_nx == ST_DATA) ? sel_onehot_s : {CH_NUM{1'b0}};
            if ((state_r == ST_IDLE) && win_found_s) begin
                sel_r       <= win_s;
                len_r       <= burst_len;
                beat_cnt_r  <= {LEN_W{1'b0}};
                wr.cmd_addr <= win_addr_s;
                wr.cmd_len  <= burst_len - LEN_ONE;
                wr.cmd_ch   <= win_s;
            end
            if ((state_r == ST_DATA) && wr.data_beat) begin
                beat_cnt_r <= beat_inc_s[LEN_W-1:0];
                if ((wr.data_last && !hit_s) || (hit_s && !wr.data_last)) begin
                    len_err <= 1'b1;
                end
            end
            if (state_r == ST_DONE) begin
                ptr_r <= sel_r;
            end
        end
    end

    // Per-channel offset, bank, deferred-load bookkeeping and frame-done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < CH_NUM; j++) begin
                off_r[j] <= {ADDR_W{1'b0}};
            end
            bank_r        <= {CH_NUM{1'b0}};
            pend_r        <= {CH_NUM{1'b0}};
            ch_frame_done <= {CH_NUM{1'b0}};
        end else begin
            for (int j = 0; j < CH_NUM; j++) begin
                if (active_s && (3'(j) == sel_r)) begin
                    if (state_r == ST_DONE) begin
                        pend_r[j] <= 1'b0;
                        if (pend_r[j] || ch_load[j]) begin
                            off_r[j]         <= {ADDR_W{1'b0}};
                            bank_r[j]        <= tog_s ? ~bank_r[j] : 1'b0;
                            ch_frame_done[j] <= 1'b1;
                        end else begin
                            off_r[j]         <= off_next_s;
                            ch_frame_done[j] <= 1'b0;
                        end
                    end else begin
                        pend_r[j]        <= pend_r[j] | ch_load[j];
                        ch_frame_done[j] <= 1'b0;
                    end
                end else if (ch_load[j]) begin
                    off_r[j]         <= {ADDR_W{1'b0}};
                    bank_r[j]        <= tog_s ? ~bank_r[j] : 1'b0;
                    ch_frame_done[j] <= 1'b1;
                end else begin
                    ch_frame_done[j] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ddr_wr_arbiter_nch.sv
// Self-checking bench for ddr_wr_arbiter_nch: directed scenarios followed by
// randomized bursts, checked against a per-channel offset/bank/pointer model.
module tb_ddr_wr_arbiter_nch;
    localparam int CH = 4;

    logic             clk, rst;
    logic [CH-1:0]    ch_load;
    logic [9:0]       fifo  [CH];
    logic [28:0]      beg_a [CH];
    logic [28:0]      end_a [CH];
    logic [CH*10-1:0] ch_fifo_cnt;
    logic [CH*29-1:0] ch_beg_addr, ch_end_addr;
    logic [7:0]       burst_len;
    logic [CH-1:0]    ch_bank, ch_frame_done;
    logic             busy, len_err;

    int total, bad, bl;
    int m_off [CH];
    int m_bank [CH];
    int m_ptr, m_len_err;

    ddr_wr_arbiter_nch_if #(.CH_NUM(CH), .ADDR_W(29), .LEN_W(8)) bus ();

    assign ch_fifo_cnt = {fifo[3], fifo[2], fifo[1], fifo[0]};
    assign ch_beg_addr = {beg_a[3], beg_a[2], beg_a[1], beg_a[0]};
    assign ch_end_addr = {end_a[3], end_a[2], end_a[1], end_a[0]};
    assign burst_len   = 8'(bl);

    ddr_wr_arbiter_nch #(
        .CH_NUM(CH), .ADDR_W(29), .LEN_W(8), .CNT_W(10), .BEAT_BYTES(32), .PINGPANG(1)
    ) dut (
        .clk(clk), .rst(rst), .ch_load(ch_load), .ch_fifo_cnt(ch_fifo_cnt),
        .ch_beg_addr(ch_beg_addr), .ch_end_addr(ch_end_addr), .burst_len(burst_len),
        .wr(bus), .ch_bank(ch_bank), .ch_frame_done(ch_frame_done),
        .busy(busy), .len_err(len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= CH; k++) begin
            if (bl != 0 && int'(fifo[(m_ptr + k) % CH]) >= bl) return (m_ptr + k) % CH;
        end
        return -1;
    endfunction

    function automatic logic [CH-1:0] bank_vec();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = (m_bank[i] != 0);
        return v;
    endfunction

    function automatic logic [28:0] exp_addr(input int w);
        logic [28:0] span;
        span = end_a[w] - beg_a[w];
        return beg_a[w] + 29'(m_off[w]) + ((m_bank[w] != 0) ? span : 29'd0);
    endfunction

    task automatic zero_fifo();
        for (int i = 0; i < CH; i++) fifo[i] = 10'd0;
    endtask

    task automatic idle_load(input int j);
        ch_load = 4'b0001 << j;
        tick();
        ch_load = 4'b0000;
        m_off[j]  = 0;
        m_bank[j] = m_bank[j] ^ 1;
        chk("load_frame_done", ch_frame_done[j], 1'b1);
        chk("load_bank", ch_bank, bank_vec());
        tick();
        chk("frame_done_pulse_end", ch_frame_done[j], 1'b0);
    endtask

    // last_at: beat carrying data_last (0 = none); bp: cycles of cmd_ready low;
    // defer_beat: beat on which ch_load of the winner pulses (0 = none);
    // exp_lat: expected cycles to cmd_valid (0 = not checked).
    task automatic do_burst(input int last_at, input int bp, input int defer_beat, input int exp_lat);
        int w, cyc, n, span;
        logic [28:0] ea;
        logic [CH-1:0] oh;
        int deferred;
        w = pick();
        if (w < 0) begin
            chk("model_has_winner", 64'd0, 64'd1);
            return;
        end
        span = int'(end_a[w] - beg_a[w]);
        ea   = exp_addr(w);
        oh   = 4'b0001 << w;
        cyc  = 0;
        do begin
            tick();
            ch_load = 4'b0000;
            cyc++;
        end while (bus.cmd_valid !== 1'b1 && cyc < 40);
        chk("cmd_seen", bus.cmd_valid, 1'b1);
        if (bus.cmd_valid !== 1'b1) return;
        if (exp_lat != 0) chk("cmd_latency", cyc, exp_lat);
        chk("cmd_ch", bus.cmd_ch, w);
        chk("cmd_addr", bus.cmd_addr, ea);
        chk("cmd_len", bus.cmd_len, 8'(bl - 1));
        chk("busy_cmd", busy, 1'b1);
        for (int k = 0; k < bp; k++) begin
            tick();
            chk("bp_valid", bus.cmd_valid, 1'b1);
            chk("bp_addr", bus.cmd_addr, ea);
            chk("bp_len", bus.cmd_len, 8'(bl - 1));
            chk("bp_ch", bus.cmd_ch, w);
            chk("bp_grant", bus.grant, 4'b0000);
        end
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        chk("valid_drop", bus.cmd_valid, 1'b0);
        chk("grant_onehot", bus.grant, oh);
        n = (last_at >= 1 && last_at < bl) ? last_at : bl;
        deferred = 0;
        for (int b = 1; b <= n; b++) begin
            bus.data_beat = 1'b1;
            bus.data_last = (b == last_at);
            if (b == defer_beat) begin
                ch_load  = oh;
                deferred = 1;
            end
            tick();
            ch_load       = 4'b0000;
            bus.data_beat = 1'b0;
            bus.data_last = 1'b0;
            if (b == defer_beat) begin
                chk("defer_bank_hold", ch_bank[w], m_bank[w] != 0);
                chk("defer_no_pulse", ch_frame_done[w], 1'b0);
            end
            if (b < n) chk("grant_hold", bus.grant, oh);
        end
        chk("grant_done_low", bus.grant, 4'b0000);
        if (last_at != bl) m_len_err = 1;
        m_off[w] = m_off[w] + bl * 32;
        if (m_off[w] >= span) m_off[w] = 0;
        if (deferred != 0) begin
            m_off[w]  = 0;
            m_bank[w] = m_bank[w] ^ 1;
        end
        m_ptr = w;
        tick();
        chk("frame_done", ch_frame_done[w], deferred != 0);
        chk("bank", ch_bank, bank_vec());
        chk("len_err", len_err, m_len_err != 0);
    endtask

    initial begin
        int cyc, nl;
        total = 0; bad = 0; bl = 0;
        m_ptr = 0; m_len_err = 0;
        for (int i = 0; i < CH; i++) begin
            m_off[i] = 0; m_bank[i] = 0; fifo[i] = 10'd0;
        end
        beg_a[0] = 29'h0;     end_a[0] = 29'h1000;
        beg_a[1] = 29'h10000; end_a[1] = 29'h10800;
        beg_a[2] = 29'h20000; end_a[2] = 29'h20400;
        beg_a[3] = 29'h30000; end_a[3] = 29'h30200;
        ch_load = 4'b0000;
        bus.cmd_ready = 1'b0; bus.data_beat = 1'b0; bus.data_last = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_valid", bus.cmd_valid, 1'b0);
        chk("rst_grant", bus.grant, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_bank", ch_bank, 4'b0000);
        chk("rst_frame_done", ch_frame_done, 4'b0000);
        rst = 1'b0;
        tick();

        // single channel, 1-cycle arbitration latency, offset advance
        bl = 8; fifo[0] = 10'd8;
        do_burst(8, 0, 0, 1);
        do_burst(8, 0, 0, 0);
        zero_fifo();

        // round robin across all channels
        for (int i = 0; i < CH; i++) fifo[i] = 10'd16;
        repeat (5) do_burst(8, 0, 0, 0);
        zero_fifo();

        // wrap at span and ping-pong bank selection on channel 3
        idle_load(3);
        idle_load(3);
        fifo[3] = 10'd8;
        repeat (3) do_burst(8, 0, 0, 0);
        zero_fifo();
        idle_load(3);
        fifo[3] = 10'd8;
        do_burst(8, 0, 0, 0);
        zero_fifo();

        // deferred load on channel 2 during its data phase
        fifo[2] = 10'd8;
        do_burst(8, 0, 3, 0);
        do_burst(8, 0, 0, 0);
        zero_fifo();

        // command backpressure
        fifo[1] = 10'd8;
        do_burst(8, 5, 0, 0);
        zero_fifo();

        // load on the same cycle the channel becomes eligible
        fifo[0] = 10'd8; ch_load = 4'b0001;
        m_off[0] = 0; m_bank[0] = m_bank[0] ^ 1;
        do_burst(8, 0, 0, 2);
        zero_fifo();

        // zero burst length never arbitrates
        bl = 0;
        for (int i = 0; i < CH; i++) fifo[i] = 10'd16;
        repeat (4) tick();
        chk("bl0_no_cmd", bus.cmd_valid, 1'b0);
        chk("bl0_idle", busy, 1'b0);
        zero_fifo();
        tick();

        // randomized bursts
        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 4))
                0: bl = 1;
                1: bl = 2;
                2: bl = 4;
                3: bl = 8;
                default: bl = 16;
            endcase
            if ($urandom_range(0, 2) == 0) idle_load(int'($urandom_range(0, CH - 1)));
            for (int i = 0; i < CH; i++) fifo[i] = 10'($urandom_range(0, 20));
            if (pick() < 0) begin
                repeat (3) tick();
                chk("rand_no_cmd", bus.cmd_valid, 1'b0);
            end else begin
                nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, bl)) : 0;
                do_burst(bl, int'($urandom_range(0, 2)), nl, 0);
            end
            zero_fifo();
        end

        // length errors: early wlast, then a clean burst, then missing wlast
        bl = 8; fifo[0] = 10'd8;
        do_burst(5, 0, 0, 0);
        do_burst(8, 0, 0, 0);
        do_burst(0, 0, 0, 0);
        zero_fifo();

        // reset in the middle of a burst
        fifo[1] = 10'd8;
        cyc = 0;
        do begin tick(); cyc++; end while (bus.cmd_valid !== 1'b1 && cyc < 40);
        chk("mid_rst_cmd_seen", bus.cmd_valid, 1'b1);
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        bus.data_beat = 1'b1;
        repeat (2) tick();
        bus.data_beat = 1'b0;
        chk("mid_rst_pre_grant", bus.grant, 4'b0010);
        zero_fifo();
        rst = 1'b1;
        tick();
        chk("mid_rst_grant", bus.grant, 4'b0000);
        chk("mid_rst_valid", bus.cmd_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_len_err", len_err, 1'b0);
        chk("mid_rst_bank", ch_bank, 4'b0000);
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
